stopwatch_ctrl: RTL and testbench

//  Single-clock sequencer for the stopwatch time datapath. It replaces the

---
 rtl/stopwatch_ctrl.sv | 146 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//
// Single-clock sequencer for the stopwatch time datapath. Counting is driven
// by one-cycle tick enables instead of derived clocks. The block holds the
// mm:ss registers, runs a RUN / ADJUST / PAUSE state machine and drives the
// per-field blink selects for the display chain downstream.
//
// Ports:
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous active-high reset
//   tick_1hz     in   1      one-cycle enable, 1 Hz count tick
//   tick_2hz     in   1      one-cycle enable, 2 Hz adjust tick
//   pause_pulse  in   1      one-cycle filtered pause pulse, toggles pause
//   sel          in   1      select switch: 0 = seconds, 1 = minutes
//   adj          in   1      adjust switch: 1 = adjust mode
//   seconds      out  CNT_W  current seconds, 0..SEC_MAX
//   minutes      out  CNT_W  current minutes, 0..MIN_MAX
//   paused       out  1      high while paused
//   blink_sec    out  1      high while adjusting seconds
//   blink_min    out  1      high while adjusting minutes
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int CNT_W   = 6,
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic             tick_2hz,
    input  logic             pause_pulse,
    input  logic             sel,
    input  logic             adj,
    output logic [CNT_W-1:0] seconds,
    output logic [CNT_W-1:0] minutes,
    output logic             paused,
    output logic             blink_sec,
    output logic             blink_min
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_ADJ_SEC = 2'd1,
        S_ADJ_MIN = 2'd2,
        S_PAUSE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(SEC_MAX);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_MAX);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    state_t           target;
    logic             sec_wrap;
    logic             min_wrap;
    logic [CNT_W-1:0] seconds_next;
    logic [CNT_W-1:0] minutes_next;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The switches pick a target mode; a pause pulse
    // toggles between that target and S_PAUSE. While paused the switches
    // are ignored until the next pause pulse.
    always_comb begin
        target     = S_RUN;
        state_next = state;
        if (adj) begin
            target = sel ? S_ADJ_MIN : S_ADJ_SEC;
        end
        if (state == S_PAUSE) begin
            if (pause_pulse) begin
                state_next = target;
            end
        end else begin
            state_next = pause_pulse ? S_PAUSE : target;
        end
    end

    // Output decode straight from the state register.
    always_comb begin
        paused    = 1'b0;
        blink_sec = 1'b0;
        blink_min = 1'b0;
        case (state)
            S_PAUSE:   paused    = 1'b1;
            S_ADJ_SEC: blink_sec = 1'b1;
            S_ADJ_MIN: blink_min = 1'b1;
            default:   ;
        endcase
    end

    // Datapath next values, keyed on the pre-transition state so a tick
    // coinciding with a pause pulse still acts. Each state listens to only
    // one tick, which rules out double increments. The ">=" compare makes
    // any out-of-range value behave as MAX and wrap on the next increment.
    always_comb begin
        sec_wrap     = (seconds >= SEC_LAST);
        min_wrap     = (minutes >= MIN_LAST);
        seconds_next = seconds;
        minutes_next = minutes;
        case (state)
            S_RUN: begin
                if (tick_1hz) begin
                    if (sec_wrap) begin
                        seconds_next = '0;
                        minutes_next = min_wrap ? '0 : minutes + ONE;
                    end else begin
                        seconds_next = seconds + ONE;
                    end
                end
            end
            S_ADJ_SEC: begin
                if (tick_2hz) begin
                    seconds_next = sec_wrap ? '0 : seconds + ONE;
                end
            end
            S_ADJ_MIN: begin
                if (tick_2hz) begin
                    minutes_next = min_wrap ? '0 : minutes + ONE;
                end
            end
            default: ;
        endcase
    end

    // mm:ss registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seconds <= '0;
            minutes <= '0;
        end else begin
            seconds <= seconds_next;
            minutes <= minutes_next;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Self-checking bench for stopwatch_ctrl. A behavioural model tracks the
// expected time as plain integers and a mode (run / adjusting a field /
// paused); a compare process checks every output against it on each falling
// edge. Directed scenarios add literal expectations that pin the model.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic       pause_pulse = 1'b0;
    logic       sel = 1'b0;
    logic       adj = 1'b0;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic       paused;
    logic       blink_sec;
    logic       blink_min;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Model: time as integers, field being adjusted (0 none, 1 sec, 2 min).
    int m_sec    = 0;
    int m_min    = 0;
    int m_field  = 0;
    bit m_paused = 1'b0;

    stopwatch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .tick_2hz   (tick_2hz),
        .pause_pulse(pause_pulse),
        .sel        (sel),
        .adj        (adj),
        .seconds    (seconds),
        .minutes    (minutes),
        .paused     (paused),
        .blink_sec  (blink_sec),
        .blink_min  (blink_min)
    );

    always #5 clk = ~clk;

    // Behavioural model, stepped on the same edge the DUT samples.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sec    <= 0;
            m_min    <= 0;
            m_field  <= 0;
            m_paused <= 1'b0;
        end else begin
            if (!m_paused) begin
                if (m_field == 0 && tick_1hz) begin
                    m_sec <= ((m_min * 60 + m_sec + 1) % 3600) % 60;
                    m_min <= ((m_min * 60 + m_sec + 1) % 3600) / 60;
                end else if (m_field == 1 && tick_2hz) begin
                    m_sec <= (m_sec + 1) % 60;
                end else if (m_field == 2 && tick_2hz) begin
                    m_min <= (m_min + 1) % 60;
                end
            end
            if (pause_pulse) begin
                if (m_paused) begin
                    m_paused <= 1'b0;
                    m_field  <= adj ? (sel ? 2 : 1) : 0;
                end else begin
                    m_paused <= 1'b1;
                end
            end else if (!m_paused) begin
                m_field <= adj ? (sel ? 2 : 1) : 0;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    task automatic compareLoop();
        forever begin
            @(negedge clk);
            if (!rst && check_en) begin
                checkOutput("cyc_seconds", int'(seconds), m_sec);
                checkOutput("cyc_minutes", int'(minutes), m_min);
                checkOutput("cyc_paused", int'(paused), int'(m_paused));
                checkOutput("cyc_blink_sec", int'(blink_sec), int'(!m_paused && m_field == 1));
                checkOutput("cyc_blink_min", int'(blink_min), int'(!m_paused && m_field == 2));
            end
        end
    endtask

    // Drive one cycle of inputs from a falling edge; pulses last one cycle.
    task automatic applyStimulus(input bit t1, input bit t2, input bit pp,
                                 input bit s, input bit a);
        tick_1hz    = t1;
        tick_2hz    = t2;
        pause_pulse = pp;
        sel         = s;
        adj         = a;
        @(negedge clk);
        tick_1hz    = 1'b0;
        tick_2hz    = 1'b0;
        pause_pulse = 1'b0;
    endtask

    // Walk the time to mm:ss through the adjust modes, ending in run mode.
    task automatic setTime(input int mm, input int ss);
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 60 && m_sec != ss; i++) applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 1);
        for (int i = 0; i < 60 && m_min != mm; i++) applyStimulus(0, 1, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0);
    endtask

    initial begin
        fork
            compareLoop();
        join_none

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;
        checkOutput("reset_seconds", int'(seconds), 0);
        checkOutput("reset_paused", int'(paused), 0);

        // Run rollovers.
        setTime(0, 59);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("run_0059_sec", int'(seconds), 0);
        checkOutput("run_0059_min", int'(minutes), 1);
        setTime(59, 59);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("run_5959_sec", int'(seconds), 0);
        checkOutput("run_5959_min", int'(minutes), 0);

        // Adjust seconds.
        setTime(3, 59);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("adjsec_blink", int'(blink_sec), 1);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("adjsec_wrap_sec", int'(seconds), 0);
        checkOutput("adjsec_wrap_min", int'(minutes), 3);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("adjsec_1hz_ignored", int'(seconds), 0);

        // Adjust minutes.
        setTime(59, 10);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 1, 1);
        checkOutput("adjmin_wrap_min", int'(minutes), 0);
        checkOutput("adjmin_sec_hold", int'(seconds), 10);
        checkOutput("adjmin_blink_min", int'(blink_min), 1);
        checkOutput("adjmin_blink_sec", int'(blink_sec), 0);

        // Pause with simultaneous tick, then resume into adjust.
        setTime(0, 5);
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("pause_tick_sec", int'(seconds), 6);
        checkOutput("pause_flag", int'(paused), 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("pause_hold_sec", int'(seconds), 6);
        checkOutput("pause_blink_sec", int'(blink_sec), 0);
        checkOutput("pause_blink_min", int'(blink_min), 0);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("resume_blink_sec", int'(blink_sec), 1);
        checkOutput("resume_paused", int'(paused), 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Both ticks in run mode.
        setTime(0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("both_ticks_sec", int'(seconds), 1);
        checkOutput("both_ticks_min", int'(minutes), 0);

        // Pseudo-random traffic checked by the model every cycle.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 3) == 0, ($urandom % 3) == 0,
                          ($urandom % 12) == 0, $urandom % 2, ($urandom % 3) == 0);
        end
        if (m_paused) applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // Asynchronous reset mid-count, checked between clock edges.
        setTime(12, 33);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("pre_reset_min", int'(minutes), 12);
        checkOutput("pre_reset_sec", int'(seconds), 34);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_sec", int'(seconds), 0);
        checkOutput("async_rst_min", int'(minutes), 0);
        checkOutput("async_rst_paused", int'(paused), 0);
        checkOutput("async_rst_blink_sec", int'(blink_sec), 0);
        checkOutput("async_rst_blink_min", int'(blink_min), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("post_rst_run_sec", int'(seconds), 1);

        // Reset while paused.
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("pause_before_rst", int'(paused), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_in_pause_paused", int'(paused), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
